// File: rtl/jk_sched_pkg.sv
// Shared op encoding and op-to-j/k mapping for the JK command scheduler.
package jk_sched_pkg;
    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_APPLY} ctl_state_e;

    typedef struct packed {
        logic j;
        logic k;
    } jk_t;

    function automatic jk_t op_to_jk(input logic [1:0] op);
        jk_t r;
        case (op)
            OP_RESET:  r = '{j: 1'b0, k: 1'b1};
            OP_SET:    r = '{j: 1'b1, k: 1'b0};
            OP_TOGGLE: r = '{j: 1'b1, k: 1'b1};
            default:   r = '{j: 1'b0, k: 1'b0};
        endcase
        return r;
    endfunction
endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop storage cell; no reset, the driver clears it via j=0/k=1.
module jk_ff (
    input  logic clk,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);
    always_ff @(posedge clk) begin
        case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
        endcase
    end

    assign qbar = ~q;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr, one-hot grant plus encoded id.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  id
);
    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                id        = cand;
            end
        end
    end
endmodule

// File: rtl/jk_cmd_sched.sv
// Round-robin scheduler applying hold/reset/set/toggle commands to a shared jk_ff bank.
// Optional JK_CMD_SCHED_BROADCAST_EN adds req_bcast to drive one op onto every flop.
module jk_cmd_sched
    import jk_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IDXW*NREQ-1:0] req_idx,
`ifdef JK_CMD_SCHED_BROADCAST_EN
    input  logic [NREQ-1:0]      req_bcast,
`endif
    output logic [NREQ-1:0]      req_ready,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 err
);
    ctl_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d, win_id;
    logic [1:0]      op_q, op_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            bcast_q, bcast_d;
    logic [NREQ-1:0] gnt;
    logic            xfer, apply, oor;
    jk_t             cmd_jk;
    logic [WIDTH-1:0] j_v, k_v, qbar_unused;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .id  (win_id)
    );

    assign req_ready = rst ? '0 : gnt;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        state_d = xfer ? ST_APPLY : ST_IDLE;
        ptr_d   = ptr_q;
        op_d    = op_q;
        idx_d   = idx_q;
        bcast_d = bcast_q;
        if (xfer) begin
            ptr_d = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
            op_d  = req_op[2*win_id +: 2];
            idx_d = req_idx[IDXW*win_id +: IDXW];
`ifdef JK_CMD_SCHED_BROADCAST_EN
            bcast_d = req_bcast[win_id];
`else
            bcast_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
        op_q    <= op_d;
        idx_q   <= idx_d;
        bcast_q <= bcast_d;
    end

    assign apply  = (state_q == ST_APPLY);
    assign busy   = apply;
    assign cmd_jk = op_to_jk(op_q);
    assign oor    = int'(idx_q) >= WIDTH;
    assign err    = apply & oor & ~bcast_q;

    // Reset clears the bank through the j/k lines and wins over a command in flight.
    always_comb begin
        j_v = '0;
        k_v = '0;
        if (rst) begin
            k_v = '1;
        end else if (apply) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (bcast_q || int'(idx_q) == b) begin
                    j_v[b] = cmd_jk.j;
                    k_v[b] = cmd_jk.k;
                end
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bank
        jk_ff u_ff (
            .clk  (clk),
            .j    (j_v[g]),
            .k    (k_v[g]),
            .q    (q[g]),
            .qbar (qbar_unused[g])
        );
    end
endmodule

// File: doc/jk_cmd_sched.md
# jk_cmd_sched

Round-robin command scheduler that shares one bank of `WIDTH` JK flip-flops between `NREQ` requesters. Each requester issues hold/reset/set/toggle commands against one flop index; the block arbitrates, registers the winning command, and drives the bank's `j`/`k` lines for exactly one clock. It sits between control requesters and the `jk_ff` storage bank and owns the bank's reset.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: number of JK flops in the bank, 2..32.
- `IDXW`, `$clog2(WIDTH)` (derived, min 1): index width.

- `clk`  in  1: rising-edge clock, single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester command valid.
- `req_op`  in  2*NREQ: per-requester op; slice r is `[2r+1:2r]`.
- `req_idx`  in  IDXW*NREQ: per-requester target flop index.
- `req_ready`  out  NREQ: one-hot grant; a transfer occurs when `req_valid[r] & req_ready[r]`.
- `q`  out  WIDTH: bank state.
- `busy`  out  1: a registered command is being applied this cycle.
- `err`  out  1: one-cycle pulse; the accepted command had `idx >= WIDTH`.

## Operation
- Op encoding: `j = op[1]`, `k = op[0]`. 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- Arbitration is combinational round-robin over `req_valid`, starting at pointer `ptr`. The winner gets `req_ready`, and at most one bit is set. `req_ready` is 0 while `rst`=1.
- Accept edge: the winner's op, idx and id are registered into the command stage (`cmd_vld`=1). `ptr` becomes winner+1 mod NREQ. `ptr` does not change when there is no transfer.
- Apply cycle: with `cmd_vld`=1, only flop `cmd_idx` gets `j`/`k` from `cmd_op`; all others get 00. `busy`=`cmd_vld`.
- Out-of-range index: the command is still accepted. No flop is driven, and `err`=1 during the apply cycle.
- The pipeline accepts a new command every cycle, so there are no bubbles and no backpressure beyond arbitration. Requesters must hold valid/op/idx stable until ready.
- Reset: with `rst`=1, all flops are driven `j`=0/`k`=1. `cmd_vld`, `err` and `ptr` go to 0. A pending command is discarded.
- Reset values after the first `rst` edge: `q`=0, `busy`=0, `err`=0, `req_ready`=0 while `rst` is held, `ptr`=0.
- Controller states are RESET (`rst` high) and RUN. RUN has two sub-phases, idle and applying, selected by `cmd_vld`.

## Timing
- Latency: `req_valid` sampled high with `ready` at edge E0; `q` reflects the op at edge E1. The request-to-`q` latency is 2 edges from the start of the request cycle.
- `busy` and `err` are high during the cycle between E0 and E1.
- Back-to-back commands to the same index apply in acceptance order, one per cycle. For example, TOGGLE, TOGGLE yields the original value after two edges.
- Simultaneous `rst` and handshake: `rst` wins. `ready`=0, so no transfer occurs.
- `rst` asserted in the apply cycle: the clear overrides the command.

## Configuration
- `JK_CMD_SCHED_BROADCAST_EN` defined:
  - Adds input `req_bcast` (NREQ).
  - An accepted command with `bcast`=1 drives `cmd_op` onto all WIDTH flops, and `idx` is ignored.
  - `err` is never raised for a broadcast.
- Not defined: the port is absent and only single-index commands exist.

## Structure
- Shared package `jk_sched_pkg` holds `OP_HOLD`, `OP_RESET`, `OP_SET` and `OP_TOGGLE` (2-bit localparams), plus the op-to-j/k mapping function.
- Sub-module `rr_arbiter` takes `NREQ`, `req` and `ptr` in, and produces a one-hot `gnt` plus the encoded winner id.
- The bank is built from WIDTH instances of the existing `jk_ff` (`.clk`, `.j`, `.k`, `.q`, `.qbar`).
- Estimated size is about 200 lines of RTL.

## Test plan
- Reset: hold `rst` for 2 cycles with all `req_valid`=1. Expect `req_ready`=0, `q`=8'h00, `busy`=0, `err`=0.
- Single SET: req0 issues SET with idx 3. Expect `ready0` high in that cycle, `busy` high in the next cycle, and `q`=8'h08 after the following edge.
- Toggle sequence on idx 0 from `q`=0: TOGGLE, TOGGLE, RESET, HOLD. Expect `q[0]` to go 1, 0, 0, 0 on consecutive edges.
- Fairness: all 4 requesters continuously valid, SET to idx 0..3. Expect grants in order 0,1,2,3,0 with one `ready` per cycle and `q`=8'h0F after 5 edges.
- Out of range: `WIDTH`=6, idx 7, op SET. Expect the command accepted, `err` pulsed for exactly one cycle, and `q` unchanged.
- Reset mid-operation: SET idx 5 accepted, then `rst`=1 in the apply cycle. Expect `q`=0, `err`=0, and `busy`=0 after that edge.
- With the macro defined: TOGGLE with `bcast`=1 from `q`=8'h0F. Expect `q`=8'hF0.
